pb_conditioner: RTL and testbench
=================================

// Module: pb_conditioner
// PURPOSE
//  Front end for the pushbutton ALU selector. Takes the raw, bouncing, active-low
//  LEFT/RIGHT pushbuttons and synchronises and debounces them. Produces clean
//  active-low levels for the selector, one-cycle press pulses, and a sticky
//  operation select that holds until the next press.
//  Sits between board pins and the selector; all outputs are registered in the clk domain.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  cycles a raw level must hold before it is accepted (min 2; 5 ms @ 50 MHz)
//  REPEAT_DELAY     25000000 cycles held before the first auto-repeat pulse (PB_REPEAT_EN only)
//  REPEAT_PERIOD    5000000 cycles between later auto-repeat pulses (PB_REPEAT_EN only)
// PORTS
//  clk                   in   1  system clock; all logic is rising-edge
//  rst                   in   1  asynchronous, active-high reset
//  not_LEFT_raw          in   1  raw LEFT button, active-low, asynchronous to clk
//  not_RIGHT_raw         in   1  raw RIGHT button, active-low, asynchronous to clk
//  not_LEFT_pushbutton   out  1  debounced LEFT level, active-low
//  not_RIGHT_pushbutton  out  1  debounced RIGHT level, active-low
//  left_press            out  1  one-cycle pulse on each accepted LEFT press (or repeat)
//  right_press           out  1  one-cycle pulse on each accepted RIGHT press (or repeat)
//  op_sel                out  2  sticky select: 00 none, 10 AND (LEFT), 01 ADD (RIGHT)
// BEHAVIOUR
//  Reset values: not_*_pushbutton=1 (released), *_press=0, op_sel=2'b00.
//    Synchroniser flops reset to 1. Counters reset to 0.
//  Sync: a 2-flop synchroniser per button; the raw inputs reach no other logic.
//  Debounce, per channel: compare the synced level with the stable level.
//   - equal: cnt <= 0.
//   - differ and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - differ and cnt == DEBOUNCE_CYCLES-1: stable <= synced, cnt <= 0.
//   - any glitch shorter than DEBOUNCE_CYCLES resets the count; the stable level is unchanged.
//  Latency: the clean output changes 2+DEBOUNCE_CYCLES cycles after a clean raw edge.
//  Press pulse: asserted the cycle after the stable level goes 1->0 (press).
//    A release (0->1) gives no pulse.
//  op_sel: a LEFT pulse loads 10 and a RIGHT pulse loads 01.
//    If both pulse in the same cycle, RIGHT wins (01).
//    With no pulse, op_sel holds.
//  Counter width: $clog2(DEBOUNCE_CYCLES); the counter never wraps (it saturates at the compare).
//  Both buttons are debounced independently. Simultaneous holds give both clean levels low.
//  rst asserted mid-count or mid-press: all state clears immediately.
//    After release, a button still held is re-accepted as a new press once debounced.
// CONFIGURATION
//  PB_REPEAT_EN defined: while a stable level stays pressed, a per-channel repeat counter runs.
//    It emits a *_press pulse REPEAT_DELAY cycles after the initial press pulse.
//    It then emits one every REPEAT_PERIOD cycles until release. Release clears the counter.
//    Repeat pulses update op_sel like normal presses.
//  PB_REPEAT_EN undefined: there is no repeat logic. REPEAT_* are unused and there is exactly one pulse per press.
// STRUCTURE
//  pb_pkg: localparam encodings OP_NONE=2'b00, OP_AND=2'b10, OP_ADD=2'b01.
//    Also the default DEBOUNCE_CYCLES and a PB_RELEASED=1'b1 constant.
//  Sub-module pb_debounce_ch: synchroniser, debounce counter, stable level, press pulse and optional repeat.
//    It is instantiated twice (LEFT, RIGHT). The top level holds only the op_sel arbitration.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Reset with both raw=1 -> outputs are 1,1,0,0,00. Hold 20 cycles -> no change.
//  2. LEFT raw 1->0 clean -> not_LEFT_pushbutton=0 at cycle 6.
//     left_press is high for exactly 1 cycle and op_sel=10. Release -> no pulse; op_sel holds 10.
//  3. RIGHT raw bounces 0,1,0,1 (2 cycles each) then a steady 0.
//     -> no change during the bounce; one right_press 6 cycles after the last edge; op_sel=01.
//  4. Both raw drop in the same cycle -> left_press and right_press pulse together; op_sel=01.
//  5. rst pulses while LEFT has been held for 3 cycles -> outputs return to reset values at once.
//     Keep holding -> press accepted 6 cycles after rst drops.
//  6. PB_REPEAT_EN, hold RIGHT 30 cycles -> pulses at t0, t0+10, t0+13, t0+16 ...
//     Undefined build -> a single pulse at t0.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared constants for the pushbutton conditioner: op_sel encodings,
// default timing parameters and the released button level.
package pb_pkg;

    typedef logic [1:0] op_sel_t;

    localparam op_sel_t OP_NONE = 2'b00;
    localparam op_sel_t OP_AND  = 2'b10;
    localparam op_sel_t OP_ADD  = 2'b01;

    // 5 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    // 0.5 s before the first repeat, then every 0.1 s
    localparam int REPEAT_DELAY_DEF    = 25000000;
    localparam int REPEAT_PERIOD_DEF   = 5000000;

    // Buttons are active-low, so an idle pin reads high
    localparam logic PB_RELEASED = 1'b1;

    // RIGHT has priority when both channels pulse in the same cycle
    function automatic op_sel_t op_next(
        input logic    left,
        input logic    right,
        input op_sel_t cur
    );
        op_sel_t nxt;
        nxt = cur;
        if (right) begin
            nxt = OP_ADD;
        end else if (left) begin
            nxt = OP_AND;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level
// and press pulse. Auto-repeat is built only when PB_REPEAT_EN is defined.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw_n,
    output logic o_level_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic          w_edge;
    logic          w_fire;

    // Two-flop synchroniser; the raw pin feeds nothing else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= PB_RELEASED;
            r_sync2 <= PB_RELEASED;
        end else begin
            r_sync1 <= i_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= PB_RELEASED;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A press is the stable level falling from released to pressed
    assign w_edge = (r_stable_d == PB_RELEASED) &&
                    (r_stable != PB_RELEASED);

`ifdef PB_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);

    logic [RW-1:0] r_rcnt;
    logic          r_first;
    logic [RW-1:0] w_rlim;
    logic          w_rfire;

    // First interval is the long delay, later ones the short period
    assign w_rlim  = r_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    assign w_rfire = (r_stable != PB_RELEASED) && !w_edge &&
                     (r_rcnt == w_rlim);

    // Repeat timer: restarts on each pulse, cleared while released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt  <= '0;
            r_first <= 1'b1;
        end else if (r_stable == PB_RELEASED) begin
            r_rcnt  <= '0;
            r_first <= 1'b1;
        end else if (w_edge) begin
            r_rcnt  <= RW'(1);
            r_first <= 1'b1;
        end else if (w_rfire) begin
            r_rcnt  <= RW'(1);
            r_first <= 1'b0;
        end else if (r_rcnt != w_rlim) begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    assign w_fire = w_edge | w_rfire;
`else
    logic w_unused_rpt;

    assign w_unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign w_fire       = w_edge;
`endif

    // Delayed stable level and registered one-cycle press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= PB_RELEASED;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= w_fire;
        end
    end

    assign o_level_n = r_stable;
    assign o_press   = r_press;

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton front end: two debounced channels plus sticky op_sel.
// Define PB_REPEAT_EN to enable auto-repeat press pulses while held.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       not_LEFT_raw,
    input  logic       not_RIGHT_raw,
    output logic       not_LEFT_pushbutton,
    output logic       not_RIGHT_pushbutton,
    output logic       left_press,
    output logic       right_press,
    output logic [1:0] op_sel
);

    logic    w_left_press;
    logic    w_right_press;
    op_sel_t r_op_sel;

    pb_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_left (
        .clk       (clk),
        .rst       (rst),
        .i_raw_n   (not_LEFT_raw),
        .o_level_n (not_LEFT_pushbutton),
        .o_press   (w_left_press)
    );

    pb_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_right (
        .clk       (clk),
        .rst       (rst),
        .i_raw_n   (not_RIGHT_raw),
        .o_level_n (not_RIGHT_pushbutton),
        .o_press   (w_right_press)
    );

    // Sticky select, loaded by whichever press pulse arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_sel <= OP_NONE;
        end else begin
            r_op_sel <= op_next(w_left_press, w_right_press, r_op_sel);
        end
    end

    assign left_press  = w_left_press;
    assign right_press = w_right_press;
    assign op_sel      = r_op_sel;

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Expected press pulses are queued when stimulus is driven.
module tb_pb_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l_raw = 1'b1;
    logic       r_raw = 1'b1;
    logic       l_lvl;
    logic       r_lvl;
    logic       l_prs;
    logic       r_prs;
    logic [1:0] op;

    typedef struct {
        int   cyc;
        logic l;
        logic r;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    pb_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .not_LEFT_raw         (l_raw),
        .not_RIGHT_raw        (r_raw),
        .not_LEFT_pushbutton  (l_lvl),
        .not_RIGHT_pushbutton (r_lvl),
        .left_press           (l_prs),
        .right_press          (r_prs),
        .op_sel               (op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every observed pulse must match the queue head
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (l_prs || r_prs) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_press: cycle %0d got l=%b r=%b want none",
                         cyc, l_prs, r_prs);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || l_prs !== e.l || r_prs !== e.r) begin
                    n_fail++;
                    $display("FAIL press_pulse: got cycle %0d l=%b r=%b want cycle %0d l=%b r=%b",
                             cyc, l_prs, r_prs, e.cyc, e.l, e.r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "timeout");
    end

    // Queue the initial press and any repeats while the level stays low
    task automatic push_hold(input int t0, input int rel_edge,
                             input logic l, input logic r);
        exp_t e;
        e.cyc = t0;
        e.l   = l;
        e.r   = r;
        sb.push_back(e);
`ifdef PB_REPEAT_EN
        for (int p = t0 + 10; p <= rel_edge; p += 3) begin
            e.cyc = p;
            sb.push_back(e);
        end
`else
        if (rel_edge < t0) $display("note: release before press");
`endif
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        l_raw = 1'b1;
        r_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({l_lvl, r_lvl, l_prs, r_prs, op} !== 6'b11_00_00) begin
            n_fail++;
            $display("FAIL reset_vals: got %b want 110000",
                     {l_lvl, r_lvl, l_prs, r_prs, op});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({l_lvl, r_lvl, l_prs, r_prs, op} !== 6'b11_00_00) begin
                n_fail++;
                $display("FAIL reset_hold: cycle %0d got %b want 110000",
                         i, {l_lvl, r_lvl, l_prs, r_prs, op});
            end
        end
    endtask

    task automatic test_right_bounce();
        int n;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            r_raw = k[0];
            @(negedge clk);
        end
        @(negedge clk);
        r_raw = 1'b0;
        n = cyc + 1;
        push_hold(n + 6, n + 15, 1'b0, 1'b1);
        wait_to(n + 4);
        n_checks++;
        if (r_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_level_early: got %b want 1", r_lvl);
        end
        wait_to(n + 5);
        n_checks++;
        if (r_lvl !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_level: got %b want 0", r_lvl);
        end
        wait_to(n + 8);
        n_checks++;
        if (op !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_op_sel: got %b want 01", op);
        end
        wait_to(n + 9);
        @(negedge clk);
        r_raw = 1'b1;
        wait_to(n + 23);
        n_checks++;
        if (sb.size() != 0 || r_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_done: got pending=%0d lvl=%b want 0 1",
                     sb.size(), r_lvl);
        end
    endtask

    task automatic test_left_press();
        int n;
        @(negedge clk);
        l_raw = 1'b0;
        n = cyc + 1;
        push_hold(n + 6, n + 18, 1'b1, 1'b0);
        wait_to(n + 4);
        n_checks++;
        if (l_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL left_level_early: got %b want 1", l_lvl);
        end
        wait_to(n + 5);
        n_checks++;
        if (l_lvl !== 1'b0) begin
            n_fail++;
            $display("FAIL left_level: got %b want 0", l_lvl);
        end
        wait_to(n + 6);
        n_checks++;
        if (l_prs !== 1'b1) begin
            n_fail++;
            $display("FAIL left_pulse_on: got %b want 1", l_prs);
        end
        wait_to(n + 7);
        n_checks++;
        if (l_prs !== 1'b0 || op !== 2'b10) begin
            n_fail++;
            $display("FAIL left_pulse_off: got prs=%b op=%b want 0 10",
                     l_prs, op);
        end
        wait_to(n + 12);
        @(negedge clk);
        l_raw = 1'b1;
        wait_to(n + 17);
        n_checks++;
        if (l_lvl !== 1'b0) begin
            n_fail++;
            $display("FAIL left_release_early: got %b want 0", l_lvl);
        end
        wait_to(n + 18);
        n_checks++;
        if (l_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL left_release: got %b want 1", l_lvl);
        end
        wait_to(n + 26);
        n_checks++;
        if (op !== 2'b10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL left_hold_op: got op=%b pending=%0d want 10 0",
                     op, sb.size());
        end
    endtask

    task automatic test_both();
        int n;
        @(negedge clk);
        l_raw = 1'b0;
        r_raw = 1'b0;
        n = cyc + 1;
        push_hold(n + 6, n + 15, 1'b1, 1'b1);
        wait_to(n + 5);
        n_checks++;
        if ({l_lvl, r_lvl} !== 2'b00) begin
            n_fail++;
            $display("FAIL both_levels: got %b want 00", {l_lvl, r_lvl});
        end
        wait_to(n + 8);
        n_checks++;
        if (op !== 2'b01) begin
            n_fail++;
            $display("FAIL both_op_sel: got %b want 01", op);
        end
        wait_to(n + 9);
        @(negedge clk);
        l_raw = 1'b1;
        r_raw = 1'b1;
        wait_to(n + 23);
        n_checks++;
        if (sb.size() != 0 || {l_lvl, r_lvl} !== 2'b11) begin
            n_fail++;
            $display("FAIL both_done: got pending=%0d lvl=%b want 0 11",
                     sb.size(), {l_lvl, r_lvl});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int r;
        @(negedge clk);
        l_raw = 1'b0;
        n = cyc + 1;
        wait_to(n + 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({l_lvl, r_lvl, l_prs, r_prs, op} !== 6'b11_00_00) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 110000",
                     {l_lvl, r_lvl, l_prs, r_prs, op});
        end
        @(negedge clk);
        rst = 1'b0;
        r = cyc + 1;
        push_hold(r + 6, r + 15, 1'b1, 1'b0);
        wait_to(r + 4);
        n_checks++;
        if (l_lvl !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_level_early: got %b want 1", l_lvl);
        end
        wait_to(r + 5);
        n_checks++;
        if (l_lvl !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_level: got %b want 0", l_lvl);
        end
        wait_to(r + 8);
        n_checks++;
        if (op !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_op_sel: got %b want 10", op);
        end
        wait_to(r + 9);
        @(negedge clk);
        l_raw = 1'b1;
        wait_to(r + 23);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_done: got pending=%0d want 0", sb.size());
        end
    endtask

    task automatic test_repeat();
        int n;
        @(negedge clk);
        r_raw = 1'b0;
        n = cyc + 1;
        push_hold(n + 6, n + 35, 1'b0, 1'b1);
        wait_to(n + 29);
        @(negedge clk);
        r_raw = 1'b1;
        wait_to(n + 45);
        n_checks++;
        if (sb.size() != 0 || op !== 2'b01) begin
            n_fail++;
            $display("FAIL repeat_done: got pending=%0d op=%b want 0 01",
                     sb.size(), op);
        end
    endtask

    initial begin
        test_reset();
        test_right_bounce();
        test_left_press();
        test_both();
        test_reset_mid();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
